// File: rtl/riscv_imm_pkg.sv
// ============================================================================
//  Module      : riscv_imm_pkg
//  Description : Shared RV32I immediate definitions: immsrc selector codes,
//                per-type instruction-word field masks, field placement.
//                Used by both the immediate extender and the encoder.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package riscv_imm_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    // Instruction-word bits owned by each immediate format
    localparam logic [31:0] c_MASK_I = 32'hFFF0_0000;
    localparam logic [31:0] c_MASK_S = 32'hFE00_0F80;
    localparam logic [31:0] c_MASK_B = 32'hFE00_0F80;
    localparam logic [31:0] c_MASK_J = 32'hFFFF_F000;

    // Stage-1 payload of the encoder pipeline
    typedef struct packed {
        logic [1:0]      immsrc;
        logic [XLEN-1:0] imm;
        logic [31:0]     base;
    } imm_req_t;

    function automatic logic [31:0] imm_field_mask(input logic [1:0] immsrc);
        logic [31:0] m;
        case (immsrc)
            IMM_I:   m = c_MASK_I;
            IMM_S:   m = c_MASK_S;
            IMM_B:   m = c_MASK_B;
            default: m = c_MASK_J;
        endcase
        return m;
    endfunction

    // Scatter immediate bits into their instruction positions; all other bits zero.
    // High bits beyond the format width and imm[0] for B/J are simply not used.
    function automatic logic [31:0] imm_place(input logic [1:0] immsrc, input logic [XLEN-1:0] imm);
        logic [31:0] p;
        p = 32'h0;
        case (immsrc)
            IMM_I: begin
                p[31:20] = imm[11:0];
            end
            IMM_S: begin
                p[31:25] = imm[11:5];
                p[11:7]  = imm[4:0];
            end
            IMM_B: begin
                p[31]    = imm[12];
                p[30:25] = imm[10:5];
                p[11:8]  = imm[4:1];
                p[7]     = imm[11];
            end
            default: begin
                p[31]    = imm[20];
                p[30:21] = imm[10:1];
                p[20]    = imm[11];
                p[19:12] = imm[19:12];
            end
        endcase
        return p;
    endfunction

endpackage

`default_nettype wire

// File: rtl/imm_range_check.sv
// ============================================================================
//  Module      : imm_range_check
//  Description : Combinational representability check of a 32-bit immediate
//                for the selected RV32I format (range and alignment).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_range_check
    import riscv_imm_pkg::*;
(
    input  logic [1:0]      i_immsrc,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_err
);

    // A value fits an N-bit signed field when bits [31:N-1] are all equal
    always_comb begin
        o_err = 1'b0;
        case (i_immsrc)
            IMM_I, IMM_S: o_err = !((&i_imm[31:11]) || !(|i_imm[31:11]));
            IMM_B:        o_err = !((&i_imm[31:12]) || !(|i_imm[31:12])) || i_imm[0];
            default:      o_err = !((&i_imm[31:20]) || !(|i_imm[31:20])) || i_imm[0];
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/imm_encoder.sv
// ============================================================================
//  Module      : imm_encoder
//  Description : Packs a 32-bit immediate into the I/S/B/J fields of an RV32I
//                instruction word, merged over a caller-supplied base word.
//                Two-stage valid/ready pipeline, latency 2, throughput 1.
//                Optional macro IMM_RANGE_CHECK_EN adds range/alignment error
//                flag and a saturating error counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imm_encoder
    import riscv_imm_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_immsrc,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [31:0]      in_base,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] err_cnt
);

    logic        w_adv;
    logic [31:0] w_merged;
    logic        r_s1_valid;
    imm_req_t    r_s1;
    logic        r_out_valid;
    logic [31:0] r_out_instr;

    // Both stages move in lockstep whenever the output slot is free or draining
    assign w_adv    = !r_out_valid || out_ready;
    assign in_ready = w_adv;

    // Clear the selected field of the base word and drop the immediate bits in
    assign w_merged = (r_s1.base & ~imm_field_mask(r_s1.immsrc)) | imm_place(r_s1.immsrc, r_s1.imm);

    // Stage 1: capture the request on accept
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1.immsrc <= in_immsrc;
                r_s1.imm    <= in_imm;
                r_s1.base   <= in_base;
            end
        end
    end

    // Stage 2: register the merged word; word holds across bubbles and stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'h0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_instr <= w_merged;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_instr = r_out_instr;

`ifdef IMM_RANGE_CHECK_EN
    logic             w_s1_err;
    logic             r_out_err;
    logic [CNT_W-1:0] r_err_cnt;

    imm_range_check u_range_check (
        .i_immsrc (r_s1.immsrc),
        .i_imm    (r_s1.imm),
        .o_err    (w_s1_err)
    );

    // Error flag travels with its word; counter bumps as the word enters stage 2
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_err <= 1'b0;
            r_err_cnt <= '0;
        end else if (w_adv && r_s1_valid) begin
            r_out_err <= w_s1_err;
            if (w_s1_err && (r_err_cnt != {CNT_W{1'b1}})) begin
                r_err_cnt <= r_err_cnt + 1'b1;
            end
        end
    end

    assign out_err = r_out_err;
    assign err_cnt = r_err_cnt;
`else
    // Upper immediate bits only matter to the range checker
    logic w_unused_imm_hi;
    assign w_unused_imm_hi = ^r_s1.imm[31:21];

    assign out_err = 1'b0;
    assign err_cnt = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_encoder.sv
// ============================================================================
//  Module      : tb_imm_encoder
//  Description : Self-checking bench for imm_encoder: directed vector table,
//                backpressure and reset-in-flight sequences, randomized
//                traffic against a field-map reference model and extender.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imm_encoder;

    localparam int CNT_W = 16;
`ifdef IMM_RANGE_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_immsrc;
    logic [31:0]      in_imm;
    logic [31:0]      in_base;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_instr;
    logic             out_err;
    logic [CNT_W-1:0] err_cnt;

    imm_encoder #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_immsrc (in_immsrc),
        .in_imm    (in_imm),
        .in_base   (in_base),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_err   (out_err),
        .err_cnt   (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    // Reference: build the word directly from the format field map
    function automatic logic [31:0] model_encode(input logic [1:0] s, input logic [31:0] imm, input logic [31:0] base);
        case (s)
            2'd0:    return {imm[11:0], base[19:0]};
            2'd1:    return {imm[11:5], base[24:12], imm[4:0], base[6:0]};
            2'd2:    return {imm[12], imm[10:5], base[24:12], imm[4:1], imm[11], base[6:0]};
            default: return {imm[20], imm[10:1], imm[11], imm[19:12], base[11:0]};
        endcase
    endfunction

    // Reference: representability from signed numeric ranges
    function automatic logic model_bad(input logic [1:0] s, input logic [31:0] imm);
        int v;
        v = $signed(imm);
        case (s)
            2'd0, 2'd1: return (v < -2048) || (v > 2047);
            2'd2:       return (v < -4096) || (v > 4094) || imm[0];
            default:    return (v < -1048576) || (v > 1048574) || imm[0];
        endcase
    endfunction

    // Immediate extender, for round-trip checks
    function automatic logic [31:0] extend(input logic [1:0] s, input logic [31:0] i);
        case (s)
            2'd0:    return {{20{i[31]}}, i[31:20]};
            2'd1:    return {{20{i[31]}}, i[31:25], i[11:7]};
            2'd2:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] base;
        logic [31:0] exp;
        logic        bad;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [1:0]  src;
        logic [31:0] imm;
        logic [31:0] instr;
        logic        bad;
    } exp_t;

    exp_t        q[$];
    int          model_cnt = 0;
    int          n_emitted = 0;
    logic        stall_prev = 1'b0;
    logic [31:0] prev_instr = 32'h0;
    logic        prev_err = 1'b0;

    // One directed request in an otherwise idle pipe; measures latency
    task automatic run_vec(input vec_t t);
        int lat;
        in_valid  = 1'b1;
        in_immsrc = t.src;
        in_imm    = t.imm;
        in_base   = t.base;
        out_ready = 1'b1;
        #1;
        check1("vec_in_ready", in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 8) begin
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check32("vec_latency", 32'(lat), 32'd2);
        check32("vec_instr", out_instr, t.exp);
        check1("vec_err", out_err, CHK & t.bad);
        check32("vec_err_cnt", {16'h0, err_cnt}, CHK ? 32'(t.cnt) : 32'd0);
        if (!t.bad) check32("vec_roundtrip", extend(t.src, out_instr), t.imm);
        @(posedge clk); @(negedge clk);
    endtask

    // One cycle of scoreboard-checked traffic, called at the negedge
    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] imm,
                        input logic [31:0] base, input logic ordy);
        exp_t e;
        in_valid  = v;
        in_immsrc = s;
        in_imm    = imm;
        in_base   = base;
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            check1("stall_valid", out_valid, 1'b1);
            check32("stall_instr", out_instr, prev_instr);
            check1("stall_err", out_err, prev_err);
        end
        check1("in_ready", in_ready, !out_valid || ordy);
        if (out_valid && ordy) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stale_word: got 0x%08h expected no word", out_instr);
            end else begin
                e = q.pop_front();
                n_emitted++;
                if (CHK && e.bad) model_cnt++;
                check32("sb_instr", out_instr, e.instr);
                check1("sb_err", out_err, CHK & e.bad);
                check32("sb_err_cnt", {16'h0, err_cnt}, 32'(model_cnt));
                if (!e.bad) check32("sb_roundtrip", extend(e.src, out_instr), e.imm);
            end
        end
        if (v && in_ready) begin
            e.src   = s;
            e.imm   = imm;
            e.instr = model_encode(s, imm, base);
            e.bad   = model_bad(s, imm);
            q.push_back(e);
        end
        stall_prev = out_valid && !ordy;
        prev_instr = out_instr;
        prev_err   = out_err;
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        #1;
        check1("rst_out_valid", out_valid, 1'b0);
        check32("rst_err_cnt", {16'h0, err_cnt}, 32'd0);
        check1("rst_out_err", out_err, 1'b0);
        reset      = 1'b0;
        q.delete();
        model_cnt  = 0;
        stall_prev = 1'b0;
        @(posedge clk); @(negedge clk);
    endtask

    function automatic logic [31:0] rand_imm();
        int bnd[16] = '{2047, 2048, -2048, -2049, 4094, 4095, 4096, -4096,
                        -4098, 1048574, 1048576, -1048576, -1048578, 0, 1, -1};
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom;
            1:       r = 32'($urandom_range(0, 10000)) - 32'd5000;
            2:       r = 32'(bnd[$urandom_range(0, 15)]);
            default: begin
                r = $urandom;
                r = {{11{r[20]}}, r[20:1], 1'b0};
            end
        endcase
        return r;
    endfunction

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{2'd0, 32'hFFFF_FFFF, 32'h0000_0013, 32'hFFF0_0013, 1'b0, 0};
        tbl[1]  = '{2'd1, 32'h0000_0008, 32'h0000_2023, 32'h0000_2423, 1'b0, 0};
        tbl[2]  = '{2'd2, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0, 0};
        tbl[3]  = '{2'd3, 32'h0000_0800, 32'h0000_006F, 32'h0010_006F, 1'b0, 0};
        tbl[4]  = '{2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0, 0};
        tbl[5]  = '{2'd1, 32'h0000_0000, 32'hFFFF_FFFF, 32'h01FF_F07F, 1'b0, 0};
        tbl[6]  = '{2'd2, 32'h0000_0000, 32'hFFFF_FFFF, 32'h01FF_F07F, 1'b0, 0};
        tbl[7]  = '{2'd3, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0FFF, 1'b0, 0};
        tbl[8]  = '{2'd2, 32'h0000_0FFE, 32'h0000_0063, 32'h7E00_0FE3, 1'b0, 0};
        tbl[9]  = '{2'd3, 32'hFFF0_0000, 32'h0000_006F, 32'h8000_006F, 1'b0, 0};
        tbl[10] = '{2'd0, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0, 0};
        tbl[11] = '{2'd3, 32'h0000_0001, 32'h0000_006F, 32'h0000_006F, 1'b1, 1};
        tbl[12] = '{2'd0, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1, 2};
        tbl[13] = '{2'd2, 32'h0000_0003, 32'h0000_0063, 32'h0000_0163, 1'b1, 3};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_immsrc = 2'd0;
        in_imm    = 32'h0;
        in_base   = 32'h0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check1("init_out_valid", out_valid, 1'b0);
        check32("init_out_instr", out_instr, 32'h0);
        check1("init_out_err", out_err, 1'b0);
        check32("init_err_cnt", {16'h0, err_cnt}, 32'd0);
        check1("init_in_ready", in_ready, 1'b1);
        @(posedge clk); @(negedge clk);

        for (int i = 0; i < 14; i++) run_vec(tbl[i]);
        do_reset();

        // Backpressure: four back-to-back requests, then a 3-cycle stall
        n_emitted = 0;
        step(1'b1, 2'd0, 32'h0000_0011, 32'h0000_0013, 1'b1);
        step(1'b1, 2'd1, 32'hFFFF_FFF0, 32'h0000_2023, 1'b1);
        step(1'b1, 2'd2, 32'h0000_0020, 32'h0000_0063, 1'b1);
        step(1'b1, 2'd3, 32'h0001_2344, 32'h0000_006F, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 2'd0, 32'h0, 32'h0, 1'b0);
            check1("bp_in_ready_low", in_ready, 1'b0);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        check32("bp_emitted", 32'(n_emitted), 32'd4);
        check32("bp_queue_empty", 32'(q.size()), 32'd0);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), rand_imm(),
                 $urandom, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 10; i++) step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
        check32("rand_queue_empty", 32'(q.size()), 32'd0);

        // Reset with two requests in flight; nothing may come out afterwards
        step(1'b1, 2'd3, 32'h0000_0001, 32'h0000_006F, 1'b1);
        step(1'b1, 2'd0, 32'h0000_0800, 32'h0000_0013, 1'b1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
            check1("post_rst_idle", out_valid, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
